// File: rtl/freq_sweep.sv
// freq_sweep: steps FREQ_VAL from a start value to a stop value in fixed
// increments, holding each value for a programmable dwell, then pulses done.
module freq_sweep #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DWELL_W = 24
) (
    input  logic               clk_in,
    input  logic               RSTN,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   start_val,
    input  logic [WIDTH-1:0]   stop_val,
    input  logic [WIDTH-1:0]   step_val,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   FREQ_VAL,
    output logic               freq_update,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_r;
    logic [WIDTH-1:0]   stop_r;
    logic [WIDTH-1:0]   step_r;
    logic               dir_up;

    logic [DWELL_W-1:0] dwell_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   next_val;

    // Effective dwell (0 behaves as 1) and clamped next frequency value.
    // The extra top bit of sum/diff catches carry-out and borrow so the
    // final step lands exactly on stop without wrapping.
    always_comb begin
        dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
        sum       = {1'b0, FREQ_VAL} + {1'b0, step_r};
        diff      = {1'b0, FREQ_VAL} - {1'b0, step_r};
        if (step_r == '0) begin
            next_val = stop_r;
        end else if (dir_up) begin
            next_val = (sum > {1'b0, stop_r}) ? stop_r : sum[WIDTH-1:0];
        end else begin
            next_val = (diff[WIDTH] || (diff[WIDTH-1:0] < stop_r)) ? stop_r : diff[WIDTH-1:0];
        end
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk_in or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            cnt         <= '0;
            dwell_r     <= '0;
            stop_r      <= '0;
            step_r      <= '0;
            dir_up      <= 1'b0;
            FREQ_VAL    <= '0;
            freq_update <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            freq_update <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state       <= HOLD;
                        stop_r      <= stop_val;
                        step_r      <= step_val;
                        dwell_r     <= dwell_eff;
                        dir_up      <= (start_val <= stop_val);
                        cnt         <= dwell_eff;
                        FREQ_VAL    <= start_val;
                        freq_update <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt <= DWELL_W'(1)) begin
                        if (FREQ_VAL == stop_r) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            FREQ_VAL    <= next_val;
                            cnt         <= dwell_r;
                            freq_update <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_sweep.sv
// Scoreboard bench for freq_sweep: stimulus pushes expected update/done
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_freq_sweep;

    logic        clk_in = 1'b0;
    logic        RSTN;
    logic        start;
    logic        abort;
    logic [31:0] start_val;
    logic [31:0] stop_val;
    logic [31:0] step_val;
    logic [23:0] dwell;
    logic [31:0] FREQ_VAL;
    logic        freq_update;
    logic        busy;
    logic        done;

    freq_sweep #(.WIDTH(32), .DWELL_W(24)) dut (
        .clk_in      (clk_in),
        .RSTN        (RSTN),
        .start       (start),
        .abort       (abort),
        .start_val   (start_val),
        .stop_val    (stop_val),
        .step_val    (step_val),
        .dwell       (dwell),
        .FREQ_VAL    (FREQ_VAL),
        .freq_update (freq_update),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          is_done;
        logic [31:0] val;
        int          gap;       // cycles since previous event, 0 = unchecked
        int          busy_cyc;  // for done events: expected busy-high length
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   last_cyc   = 0;
    int   busy_run   = 0;
    exp_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic exp_upd(input logic [31:0] v, input int gap);
        exp_t x;
        x.is_done = 1'b0; x.val = v; x.gap = gap; x.busy_cyc = 0;
        exp_q.push_back(x);
    endtask

    task automatic exp_done(input logic [31:0] v, input int gap, input int bc);
        exp_t x;
        x.is_done = 1'b1; x.val = v; x.gap = gap; x.busy_cyc = bc;
        exp_q.push_back(x);
    endtask

    always @(posedge clk_in) cyc++;

    // Monitor: pop and compare on every freq_update or done pulse.
    always @(negedge clk_in) begin
        if (RSTN) begin
            if (freq_update || done) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_event: got upd=%0b done=%0b val=%0h expected none", freq_update, done, FREQ_VAL);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_done", 64'(done), 64'(e.is_done));
                    chk("event_is_upd", 64'(freq_update), 64'(!e.is_done));
                    chk("event_value", 64'(FREQ_VAL), 64'(e.val));
                    if (e.gap != 0) chk("event_gap", 64'(cyc - last_cyc), 64'(e.gap));
                    if (e.is_done) begin
                        chk("busy_len", 64'(busy_run), 64'(e.busy_cyc));
                        chk("busy_at_done", 64'(busy), 64'd0);
                    end
                end
                last_cyc = cyc;
            end
            busy_run = busy ? busy_run + 1 : 0;
        end else begin
            busy_run = 0;
        end
    end

    task automatic go(input logic [31:0] sv, input logic [31:0] ev, input logic [31:0] st, input logic [23:0] dw);
        @(negedge clk_in);
        start_val = sv; stop_val = ev; step_val = st; dwell = dw; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        chk("start_latency_upd", 64'(freq_update), 64'd1);
        chk("start_latency_busy", 64'(busy), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RSTN = 1'b0; start = 1'b0; abort = 1'b0;
        start_val = '0; stop_val = '0; step_val = '0; dwell = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_freq", 64'(FREQ_VAL), 64'd0);
        chk("rst_upd", 64'(freq_update), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        RSTN = 1'b1;
        repeat (2) @(negedge clk_in);

        // Up sweep, with input changes and a start request mid-sweep.
        exp_upd(10, 0); exp_upd(20, 3); exp_upd(30, 3); exp_upd(40, 3); exp_done(40, 3, 12);
        go(10, 40, 10, 3);
        repeat (2) @(negedge clk_in);
        stop_val = 25; start_val = 999; step_val = 1; dwell = 1; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        drain(40);
        chk("up_hold_stop", 64'(FREQ_VAL), 64'd40);

        // Down sweep with final clamp.
        exp_upd(100, 0); exp_upd(90, 1); exp_upd(80, 1); exp_upd(75, 1); exp_done(75, 1, 4);
        go(100, 75, 10, 1);
        drain(20);
        chk("down_hold_stop", 64'(FREQ_VAL), 64'd75);

        // Overflow clamp at the top of the range.
        exp_upd(32'hFFFF_FFF0, 0); exp_upd(32'hFFFF_FFFF, 2); exp_done(32'hFFFF_FFFF, 2, 4);
        go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 2);
        drain(20);
        chk("ovf_hold_stop", 64'(FREQ_VAL), 64'hFFFF_FFFF);

        // step = 0 and dwell = 0.
        exp_upd(5, 0); exp_upd(9, 1); exp_done(9, 1, 2);
        go(5, 9, 0, 0);
        drain(20);

        // start == stop.
        exp_upd(7, 0); exp_done(7, 4, 4);
        go(7, 7, 3, 4);
        drain(20);

        // Abort during the second value.
        exp_upd(10, 0); exp_upd(20, 3);
        go(10, 40, 10, 3);
        n = 0;
        while (FREQ_VAL != 32'd20 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        chk("abort_reach_20", 64'(FREQ_VAL), 64'd20);
        abort = 1'b1;
        @(negedge clk_in);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_freq", 64'(FREQ_VAL), 64'd20);
        chk("abort_upd", 64'(freq_update), 64'd0);
        repeat (10) @(negedge clk_in);
        chk("abort_queue", 64'(exp_q.size()), 64'd0);
        chk("abort_freq_later", 64'(FREQ_VAL), 64'd20);

        // start + abort in IDLE: start is dropped.
        @(negedge clk_in);
        start_val = 50; stop_val = 60; step_val = 5; dwell = 1; start = 1'b1; abort = 1'b1;
        @(negedge clk_in);
        start = 1'b0; abort = 1'b0;
        chk("collide_busy", 64'(busy), 64'd0);
        chk("collide_upd", 64'(freq_update), 64'd0);
        chk("collide_freq", 64'(FREQ_VAL), 64'd20);
        repeat (5) @(negedge clk_in);

        // Asynchronous reset mid-sweep.
        exp_upd(100, 0); exp_upd(90, 2);
        go(100, 50, 10, 2);
        repeat (2) @(negedge clk_in);
        #2 RSTN = 1'b0;
        #1;
        chk("midrst_freq", 64'(FREQ_VAL), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_upd", 64'(freq_update), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        exp_q.delete();
        @(negedge clk_in);
        RSTN = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("postrst_busy", 64'(busy), 64'd0);

        // Full sweep after reset release.
        exp_upd(10, 0); exp_upd(20, 2); exp_upd(30, 2); exp_upd(40, 2); exp_done(40, 2, 8);
        go(10, 40, 10, 2);
        drain(40);
        chk("postrst_hold_stop", 64'(FREQ_VAL), 64'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
